// File: rtl/fifo_pkg.sv
// Shared types for the FIFO32x8 read-side stream master.
package fifo_pkg;

  localparam int FIFO_TAM  = 32;
  localparam int FIFO_SIZE = 8;

  typedef logic [FIFO_SIZE-1:0]         word_t;
  typedef logic [$clog2(FIFO_TAM-1):0]  usedw_t;

  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DRAIN} rd_state_t;

endpackage

// File: rtl/reader_skid_buf.sv
// Two-entry in-order buffer that absorbs the FIFO read latency.
// Entry 0 is always the head; a pop shifts entry 1 forward.
module reader_skid_buf #(
  parameter int size = 8
) (
  input  logic            CLOCK,
  input  logic            RESET_N,
  input  logic            CLEAR_N,
  input  logic            push,
  input  logic [size-1:0] din,
  input  logic            pop,
  output logic [size-1:0] dout,
  output logic [1:0]      occ
);

  logic [size-1:0] ent0_p1;
  logic [size-1:0] ent1_p1;
  logic [1:0]      occ_p1;
  logic            do_pop;
  logic            do_push;

  assign do_pop  = pop & (occ_p1 != 2'd0);
  assign do_push = push & ((occ_p1 != 2'd2) | do_pop);

  // Buffer storage stage
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      occ_p1  <= 2'd0;
      ent0_p1 <= '0;
      ent1_p1 <= '0;
    end else if (!CLEAR_N) begin
      occ_p1 <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (occ_p1 == 2'd0) ent0_p1 <= din;
          else                ent1_p1 <= din;
          occ_p1 <= occ_p1 + 2'd1;
        end
        2'b01: begin
          ent0_p1 <= ent1_p1;
          occ_p1  <= occ_p1 - 2'd1;
        end
        2'b11: begin
          if (occ_p1 == 2'd1) begin
            ent0_p1 <= din;
          end else begin
            ent0_p1 <= ent1_p1;
            ent1_p1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout = ent0_p1;
  assign occ  = occ_p1;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for FIFO32x8: pops words and presents them as a valid/ready stream.
// Optional macro READER_THRESHOLD_EN: start a burst only once USE_DW reaches THRESH (or full).
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int tam    = 32,
  parameter int size   = 8,
  parameter int THRESH = 4
) (
  input  logic                     CLOCK,
  input  logic                     RESET_N,
  input  logic                     CLEAR_N,
  input  logic                     F_EMPTY_N,
  input  logic [$clog2(tam-1):0]   USE_DW,
  input  logic [size-1:0]          FIFO_DATA,
  output logic                     READ,
  output logic                     M_VALID,
  input  logic                     M_READY,
  output logic [size-1:0]          M_DATA,
  output logic [15:0]              WORD_CNT,
  output logic                     BUSY
);

  localparam int UW = $clog2(tam-1) + 1;

  rd_state_t  state_q;
  rd_state_t  state_d;
  logic       pend_p1;
  logic [1:0] occ;
  logic       pop;
  logic       start;
  logic [2:0] lvl;

`ifdef READER_THRESHOLD_EN
  localparam logic [UW-1:0] THRESH_W = UW'(THRESH);
  localparam logic [UW-1:0] FULL_W   = UW'(tam - 1);

  assign start = (USE_DW >= THRESH_W) | (USE_DW == FULL_W);
`else
  logic unused_cfg;

  assign unused_cfg = (^USE_DW) ^ (THRESH > 0);
  assign start      = F_EMPTY_N;
`endif

  assign M_VALID = (occ != 2'd0);
  assign pop     = M_VALID & M_READY;
  // Words held or in flight after this edge; must stay below 2 to issue another read.
  assign lvl     = {1'b0, occ} + {2'b00, pend_p1} - {2'b00, pop};
  assign READ    = CLEAR_N & F_EMPTY_N & (state_q == ST_STREAM) & (lvl < 3'd2);
  assign BUSY    = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_STREAM;
      ST_STREAM: if (!F_EMPTY_N) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (F_EMPTY_N)                           state_d = ST_STREAM;
        else if ((occ == 2'd0) && !pend_p1)      state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
    if (!CLEAR_N) state_d = ST_IDLE;
  end

  // FIFO read-latency stage and control registers
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      pend_p1  <= 1'b0;
      WORD_CNT <= 16'd0;
    end else begin
      state_q <= state_d;
      if (!CLEAR_N) begin
        pend_p1  <= 1'b0;
        WORD_CNT <= 16'd0;
      end else begin
        pend_p1 <= READ;
        if (pop) WORD_CNT <= WORD_CNT + 16'd1;
      end
    end
  end

  reader_skid_buf #(
    .size (size)
  ) u_buf (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .CLEAR_N (CLEAR_N),
    .push    (pend_p1),
    .din     (FIFO_DATA),
    .pop     (pop),
    .dout    (M_DATA),
    .occ     (occ)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader with a behavioural 32x8 FIFO and a scoreboard monitor.
`timescale 1ns/1ps
module tb_fifo_stream_reader;

  logic        clk;
  logic        rst_n;
  logic        clear_n;
  logic        f_empty_n;
  logic [5:0]  use_dw;
  logic [7:0]  fifo_data;
  logic        rd;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic [15:0] word_cnt;
  logic        busy;

  logic        wr_en;
  logic [7:0]  wr_data;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0] fq[$];
  logic [7:0] exp_q[$];

  int first_rd_cyc  = -1;
  int first_vld_cyc = -1;
  int last_pop_cyc  = -1;
  int held          = 0;
  logic       hold_prev = 1'b0;
  logic [7:0] hold_data = 8'h00;
  logic [7:0] e;

  fifo_stream_reader #(.tam(32), .size(8), .THRESH(4)) dut (
    .CLOCK     (clk),
    .RESET_N   (rst_n),
    .CLEAR_N   (clear_n),
    .F_EMPTY_N (f_empty_n),
    .USE_DW    (use_dw),
    .FIFO_DATA (fifo_data),
    .READ      (rd),
    .M_VALID   (m_valid),
    .M_READY   (m_ready),
    .M_DATA    (m_data),
    .WORD_CNT  (word_cnt),
    .BUSY      (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural FIFO32x8: DATA_OUT valid one clock after the edge sampling READ.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      f_empty_n <= 1'b0;
      use_dw    <= 6'd0;
      fifo_data <= 8'h00;
    end else if (!clear_n) begin
      fq.delete();
      f_empty_n <= 1'b0;
      use_dw    <= 6'd0;
    end else begin
      if (rd && fq.size() > 0) fifo_data <= fq.pop_front();
      if (wr_en && fq.size() < 32) fq.push_back(wr_data);
      f_empty_n <= (fq.size() != 0);
      use_dw    <= 6'(fq.size());
    end
  end

  // Monitor: scoreboard pops, read rule, and hold stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      held      = 0;
      hold_prev = 1'b0;
    end else begin
      if (rd) begin
        checks++;
        if (!f_empty_n || (held - (m_valid && m_ready ? 1 : 0)) >= 2) begin
          errors++;
          $display("FAIL read_rule: READ=1 with F_EMPTY_N=%0b held=%0d pop=%0b", f_empty_n, held, m_valid && m_ready);
        end
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
      end
      if (m_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (hold_prev) begin
        checks++;
        if (!m_valid || m_data !== hold_data) begin
          errors++;
          $display("FAIL hold_stable: M_VALID=%0b M_DATA=%02h, required 1/%02h", m_valid, m_data, hold_data);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: M_DATA=%02h delivered, none expected", m_data);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin
            errors++;
            $display("FAIL stream_data: M_DATA=%02h, required %02h", m_data, e);
          end
        end
        last_pop_cyc = cyc;
      end
      hold_prev = m_valid && !m_ready && clear_n;
      hold_data = m_data;
      if (!clear_n) held = 0;
      else          held = held + (rd ? 1 : 0) - (m_valid && m_ready ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic write_words(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + 8'(i);
      exp_q.push_back(base + 8'(i));
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int n;
    n = 0;
    while ((busy || m_valid || exp_q.size() != 0) && n < maxc) begin
      tick();
      n++;
    end
    checks++;
    if (n >= maxc) begin
      errors++;
      $display("FAIL %s_timeout: BUSY=%0b M_VALID=%0b pending=%0d after %0d cycles, required idle", name, busy, m_valid, exp_q.size(), maxc);
      exp_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n   = 1'b0;
    clear_n = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    m_ready = 1'b0;
    #5;
    chk("reset_read",    32'(rd),       0);
    chk("reset_valid",   32'(m_valid),  0);
    chk("reset_data",    32'(m_data),   0);
    chk("reset_wordcnt", 32'(word_cnt), 0);
    chk("reset_busy",    32'(busy),     0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // 1: eight words at full rate
    m_ready = 1'b1;
    first_rd_cyc = -1; first_vld_cyc = -1;
    write_words(8'h00, 8);
    wait_idle("t1", 60);
    chk("t1_first_valid_latency", 32'(first_vld_cyc - first_rd_cyc), 2);
    chk("t1_consecutive", 32'(last_pop_cyc - first_vld_cyc), 7);
    chk("t1_wordcnt", 32'(word_cnt), 8);
    chk("t1_busy", 32'(busy), 0);

    // 2: sixteen words with alternating ready
    fork
      write_words(8'h10, 16);
      begin
        for (int i = 0; i < 60; i++) begin
          m_ready = ~m_ready;
          tick();
        end
      end
    join
    m_ready = 1'b1;
    wait_idle("t2", 60);
    chk("t2_wordcnt", 32'(word_cnt), 24);

    // 3: fill the FIFO completely, then drain
    m_ready = 1'b0;
    write_words(8'h40, 34);
    tick(); tick();
    chk("t3_fifo_full", 32'(use_dw), 32);
    chk("t3_head_valid", 32'(m_valid), 1);
    chk("t3_head_data", 32'(m_data), 32'h40);
    m_ready = 1'b1;
    wait_idle("t3", 100);
    chk("t3_wordcnt", 32'(word_cnt), 58);
    chk("t3_busy", 32'(busy), 0);

    // 4: clear with one word buffered and one in flight
    m_ready = 1'b0;
    write_words(8'h80, 2);
    for (int i = 0; i < 20 && !m_valid; i++) tick();
    chk("t4_valid_seen", 32'(m_valid), 1);
    clear_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t4_read_in_clear", 32'(rd), 0);
    tick();
    clear_n = 1'b1;
    chk("t4_valid_after_clear", 32'(m_valid), 0);
    chk("t4_wordcnt", 32'(word_cnt), 0);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("t4_no_word", 32'(m_valid), 0);
    chk("t4_busy", 32'(busy), 0);

    // 5: asynchronous reset mid-burst
    write_words(8'hA0, 8);
    chk("t5_busy_before", 32'(busy), 1);
    chk("t5_valid_before", 32'(m_valid), 1);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t5_read",    32'(rd),       0);
    chk("t5_valid",   32'(m_valid),  0);
    chk("t5_data",    32'(m_data),   0);
    chk("t5_wordcnt", 32'(word_cnt), 0);
    chk("t5_busy",    32'(busy),     0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("t5_valid_after", 32'(m_valid), 0);

`ifdef READER_THRESHOLD_EN
    // 6: no burst below THRESH, full burst once reached
    first_rd_cyc = -1;
    write_words(8'hC0, 3);
    for (int i = 0; i < 5; i++) tick();
    chk("t6_no_read_below", 32'(first_rd_cyc < 0), 1);
    chk("t6_idle_below", 32'(busy), 0);
    write_words(8'hC3, 1);
    wait_idle("t6", 40);
    chk("t6_read_seen", 32'(first_rd_cyc >= 0), 1);
    chk("t6_wordcnt", 32'(word_cnt), 4);
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
